// File: rtl/mio_pkg.sv
// Shared types and constants for the LC-3 memory/IO access controller.
package mio_pkg;

   typedef enum logic [1:0] {StIdle, StMem, StDone} mio_state_e;

   typedef enum logic [1:0] {DevKbsr, DevKbdr, DevDsr, DevDdr} mio_dev_e;

   localparam logic [15:0] KBSR_ADDR_DEF = 16'hFE00;
   localparam logic [15:0] KBDR_ADDR_DEF = 16'hFE02;
   localparam logic [15:0] DSR_ADDR_DEF  = 16'hFE04;
   localparam logic [15:0] DDR_ADDR_DEF  = 16'hFE06;

   localparam int unsigned READY_BIT = 15;
   localparam int unsigned IE_BIT    = 14;

endpackage

// File: rtl/mio_access_ctrl_if.sv
// Bus between the LC-3 control path, the memory port and the keyboard/display devices.
interface mio_access_ctrl_if #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned ADDR_W = 16
);
   logic              req;
   logic              r_w;
   logic [ADDR_W-1:0] mar;
   logic [DATA_W-1:0] wdata;
   logic              ready;
   logic [DATA_W-1:0] rdata;
   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              kbd_vld;
   logic [7:0]        kbd_char;
   logic              disp_ack;
   logic              ddr_vld;
   logic [7:0]        ddr_out;
   logic              kbd_int;

   modport master (
      output req, r_w, mar, wdata, mem_rdata, kbd_vld, kbd_char, disp_ack,
      input  ready, rdata, mem_en, mem_we, mem_addr, mem_wdata, ddr_vld, ddr_out, kbd_int
   );

   modport slave (
      input  req, r_w, mar, wdata, mem_rdata, kbd_vld, kbd_char, disp_ack,
      output ready, rdata, mem_en, mem_we, mem_addr, mem_wdata, ddr_vld, ddr_out, kbd_int
   );

endinterface

// File: rtl/mio_dev_regs.sv
// Memory-mapped keyboard/display registers: KBSR, KBDR, DSR, DDR with set/clear priority.
// Optional keyboard interrupt enable is built when MIO_KBD_INT_EN is defined.
module mio_dev_regs
   import mio_pkg::*;
#(
   parameter int unsigned DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              acc_i,
   input  logic              we_i,
   input  mio_dev_e          sel_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic              kbd_vld_i,
   input  logic [7:0]        kbd_char_i,
   input  logic              disp_ack_i,
   output logic [DATA_W-1:0] rdata_o,
   output logic              ddr_vld_o,
   output logic [7:0]        ddr_out_o,
   output logic              kbd_int_o
);

   logic       kb_rdy_q, kb_rdy_d;
   logic [7:0] kbdr_q, kbdr_d;
   logic [7:0] ddr_q, ddr_d;
   logic       ddr_vld_q, ddr_vld_d;
   logic       kb_ie;
   logic       kbdr_rd, ddr_wr;
   logic       unused_wdata;

   assign kbdr_rd      = acc_i & ~we_i & (sel_i == DevKbdr);
   assign ddr_wr       = acc_i & we_i & (sel_i == DevDdr);
   assign unused_wdata = ^wdata_i;

   // A new character beats a concurrent KBDR read; a DDR write beats a concurrent ack.
   always_comb begin
      kb_rdy_d  = kb_rdy_q;
      kbdr_d    = kbdr_q;
      ddr_d     = ddr_q;
      ddr_vld_d = ddr_vld_q;
      if (kbd_vld_i) begin
         kb_rdy_d = 1'b1;
         kbdr_d   = kbd_char_i;
      end else if (kbdr_rd) begin
         kb_rdy_d = 1'b0;
      end
      if (ddr_wr) begin
         ddr_d     = wdata_i[7:0];
         ddr_vld_d = 1'b1;
      end else if (disp_ack_i) begin
         ddr_vld_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         kb_rdy_q  <= 1'b0;
         kbdr_q    <= '0;
         ddr_q     <= '0;
         ddr_vld_q <= 1'b0;
      end else begin
         kb_rdy_q  <= kb_rdy_d;
         kbdr_q    <= kbdr_d;
         ddr_q     <= ddr_d;
         ddr_vld_q <= ddr_vld_d;
      end
   end

`ifdef MIO_KBD_INT_EN
   logic kb_ie_q, kb_ie_d, kb_int_q;
   logic kbsr_wr;

   assign kbsr_wr = acc_i & we_i & (sel_i == DevKbsr);

   always_comb begin
      kb_ie_d = kb_ie_q;
      if (kbsr_wr) kb_ie_d = wdata_i[IE_BIT];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         kb_ie_q  <= 1'b0;
         kb_int_q <= 1'b0;
      end else begin
         kb_ie_q  <= kb_ie_d;
         kb_int_q <= kb_rdy_q & kb_ie_q;
      end
   end

   assign kb_ie     = kb_ie_q;
   assign kbd_int_o = kb_int_q;
`else
   assign kb_ie     = 1'b0;
   assign kbd_int_o = 1'b0;
`endif

   // DSR[15] is always the complement of DDR_VLD, so it shares the one flop.
   always_comb begin
      rdata_o = '0;
      unique case (sel_i)
         DevKbsr: begin
            rdata_o[READY_BIT] = kb_rdy_q;
            rdata_o[IE_BIT]    = kb_ie;
         end
         DevKbdr: rdata_o[7:0]      = kbdr_q;
         DevDsr:  rdata_o[READY_BIT] = ~ddr_vld_q;
         DevDdr:  rdata_o           = '0;
         default: rdata_o           = '0;
      endcase
   end

   assign ddr_vld_o = ddr_vld_q;
   assign ddr_out_o = ddr_q;

endmodule

// File: rtl/mio_access_ctrl.sv
// LC-3 memory/IO access controller: address decode, multi-cycle memory handshake, READY pulse.
// Define MIO_KBD_INT_EN to build the keyboard interrupt enable and KBD_INT output.
module mio_access_ctrl
   import mio_pkg::*;
#(
   parameter int unsigned       DATA_W    = 16,
   parameter int unsigned       ADDR_W    = 16,
   parameter int unsigned       MEM_LAT   = 3,
   parameter logic [ADDR_W-1:0] KBSR_ADDR = ADDR_W'(KBSR_ADDR_DEF),
   parameter logic [ADDR_W-1:0] KBDR_ADDR = ADDR_W'(KBDR_ADDR_DEF),
   parameter logic [ADDR_W-1:0] DSR_ADDR  = ADDR_W'(DSR_ADDR_DEF),
   parameter logic [ADDR_W-1:0] DDR_ADDR  = ADDR_W'(DDR_ADDR_DEF)
) (
   input logic               clk,
   input logic               rst_n,
   mio_access_ctrl_if.slave  bus
);

   localparam int unsigned CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);

   mio_state_e        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              ready_q, ready_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              mem_en_q, mem_en_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

   logic              is_dev;
   logic              dev_acc;
   mio_dev_e          dev_sel;
   logic [DATA_W-1:0] dev_rdata;

   always_comb begin
      is_dev  = 1'b1;
      dev_sel = DevKbsr;
      if (bus.mar == KBSR_ADDR) begin
         dev_sel = DevKbsr;
      end else if (bus.mar == KBDR_ADDR) begin
         dev_sel = DevKbdr;
      end else if (bus.mar == DSR_ADDR) begin
         dev_sel = DevDsr;
      end else if (bus.mar == DDR_ADDR) begin
         dev_sel = DevDdr;
      end else begin
         is_dev = 1'b0;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      ready_d     = 1'b0;
      rdata_d     = rdata_q;
      mem_en_d    = mem_en_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      dev_acc     = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (bus.req) begin
               if (is_dev) begin
                  // Device registers act at acceptance; data is the pre-access value.
                  dev_acc = 1'b1;
                  state_d = StDone;
                  ready_d = 1'b1;
                  if (!bus.r_w) rdata_d = dev_rdata;
               end else begin
                  state_d     = StMem;
                  cnt_d       = '0;
                  mem_en_d    = 1'b1;
                  mem_we_d    = bus.r_w;
                  mem_addr_d  = bus.mar;
                  mem_wdata_d = bus.wdata;
               end
            end
         end
         StMem: begin
            if (cnt_q == CNT_LAST) begin
               state_d  = StDone;
               ready_d  = 1'b1;
               mem_en_d = 1'b0;
               mem_we_d = 1'b0;
               if (!mem_we_q) rdata_d = bus.mem_rdata;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         ready_q     <= 1'b0;
         rdata_q     <= '0;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         ready_q     <= ready_d;
         rdata_q     <= rdata_d;
         mem_en_q    <= mem_en_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end

   mio_dev_regs #(
      .DATA_W(DATA_W)
   ) u_dev_regs (
      .clk       (clk),
      .rst_n     (rst_n),
      .acc_i     (dev_acc),
      .we_i      (bus.r_w),
      .sel_i     (dev_sel),
      .wdata_i   (bus.wdata),
      .kbd_vld_i (bus.kbd_vld),
      .kbd_char_i(bus.kbd_char),
      .disp_ack_i(bus.disp_ack),
      .rdata_o   (dev_rdata),
      .ddr_vld_o (bus.ddr_vld),
      .ddr_out_o (bus.ddr_out),
      .kbd_int_o (bus.kbd_int)
   );

   assign bus.ready     = ready_q;
   assign bus.rdata     = rdata_q;
   assign bus.mem_en    = mem_en_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mio_access_ctrl.sv
// Self-checking bench for mio_access_ctrl: directed scenarios plus randomized accesses
// checked against a register-level behavioural model.
module tb_mio_access_ctrl;

   localparam int unsigned MEM_LAT = 3;
`ifdef MIO_KBD_INT_EN
   localparam logic INT_EN = 1'b1;
`else
   localparam logic INT_EN = 1'b0;
`endif
   localparam logic [15:0] A_KBSR = 16'hFE00;
   localparam logic [15:0] A_KBDR = 16'hFE02;
   localparam logic [15:0] A_DSR  = 16'hFE04;
   localparam logic [15:0] A_DDR  = 16'hFE06;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_tests = 0;
   int   n_fail = 0;

   mio_access_ctrl_if #(.DATA_W(16), .ADDR_W(16)) bus ();

   mio_access_ctrl #(
      .DATA_W (16),
      .ADDR_W (16),
      .MEM_LAT(MEM_LAT)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   // External memory: preloaded through its own port, then written by the DUT.
   logic [15:0] tb_mem [256];
   logic        pl_en = 1'b0;
   logic [7:0]  pl_idx = '0;
   logic [15:0] pl_val = '0;

   assign bus.mem_rdata = bus.mem_en ? tb_mem[bus.mem_addr[7:0]] : 16'hDEAD;

   always @(posedge clk) begin
      if (pl_en) tb_mem[pl_idx] <= pl_val;
      else if (bus.mem_en && bus.mem_we) tb_mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
   end

   // Reference model state
   logic        m_rdy, m_ie, m_vld;
   logic [7:0]  m_kbdr, m_ddr;
   logic [15:0] m_mem [256];
   logic [15:0] last_rd;

   task automatic model_reset();
      m_rdy = 1'b0; m_ie = 1'b0; m_vld = 1'b0;
      m_kbdr = '0; m_ddr = '0; last_rd = '0;
   endtask

   task automatic kbd_strobe(input logic [7:0] c);
      bus.kbd_vld = 1'b1; bus.kbd_char = c;
      @(posedge clk); #1;
      bus.kbd_vld = 1'b0; bus.kbd_char = 8'($urandom);
      m_rdy = 1'b1; m_kbdr = c;
   endtask

   task automatic disp_ack_strobe();
      bus.disp_ack = 1'b1;
      @(posedge clk); #1;
      bus.disp_ack = 1'b0;
      m_vld = 1'b0;
   endtask

   // One access; called just after a rising edge. Optional same-cycle strobes (kv/ack),
   // and hold keeps REQ asserted (as a DDR write) while the access is in flight.
   task automatic access(input logic we, input logic [15:0] addr, input logic [15:0] wd,
                         input logic kv, input logic [7:0] kc, input logic ack,
                         input logic hold, output logic [15:0] rd);
      logic [15:0] exp;
      logic        dev, port_bad;
      int          lat, en_cyc, exp_lat, exp_en;
      dev = (addr == A_KBSR) || (addr == A_KBDR) || (addr == A_DSR) || (addr == A_DDR);
      exp = last_rd;
      if (!we) begin
         case (addr)
            A_KBSR:  exp = {m_rdy, m_ie, 14'h0};
            A_KBDR:  exp = {8'h00, m_kbdr};
            A_DSR:   exp = {~m_vld, 15'h0};
            A_DDR:   exp = 16'h0000;
            default: exp = m_mem[addr[7:0]];
         endcase
      end
      if (!we && addr == A_KBDR) m_rdy = 1'b0;
      if (kv) begin m_rdy = 1'b1; m_kbdr = kc; end
      if (we && addr == A_KBSR) m_ie = INT_EN & wd[14];
      if (we && addr == A_DDR) begin
         m_ddr = wd[7:0]; m_vld = 1'b1;
      end else if (ack) begin
         m_vld = 1'b0;
      end
      if (we && !dev) m_mem[addr[7:0]] = wd;

      bus.req = 1'b1; bus.r_w = we; bus.mar = addr; bus.wdata = wd;
      bus.kbd_vld = kv; bus.kbd_char = kc; bus.disp_ack = ack;
      @(posedge clk); #1;
      bus.kbd_vld = 1'b0; bus.disp_ack = 1'b0;
      if (hold) begin
         bus.req = 1'b1; bus.r_w = 1'b1; bus.mar = A_DDR; bus.wdata = 16'($urandom);
      end else begin
         bus.req = 1'b0; bus.r_w = 1'($urandom); bus.mar = 16'($urandom);
         bus.wdata = 16'($urandom);
      end

      lat = 1; en_cyc = 0; port_bad = 1'b0;
      while (bus.ready !== 1'b1 && lat < 40) begin
         if (bus.mem_en === 1'b1) begin
            en_cyc++;
            if (bus.mem_addr !== addr || bus.mem_we !== we || (we && bus.mem_wdata !== wd))
               port_bad = 1'b1;
         end
         @(posedge clk); #1;
         lat++;
      end
      bus.req = 1'b0;
      exp_lat = dev ? 1 : MEM_LAT + 1;
      exp_en  = dev ? 0 : MEM_LAT;
      n_tests++;
      if (lat !== exp_lat) begin
         n_fail++;
         $display("FAIL latency addr=%h we=%0b: got %0d cycles, expected %0d", addr, we, lat, exp_lat);
      end
      n_tests++;
      if (en_cyc !== exp_en || port_bad) begin
         n_fail++;
         $display("FAIL mem_port addr=%h: mem_en cycles %0d (expected %0d), port_bad=%0b",
                  addr, en_cyc, exp_en, port_bad);
      end
      n_tests++;
      if (bus.rdata !== exp) begin
         n_fail++;
         $display("FAIL rdata addr=%h we=%0b: got %h, expected %h", addr, we, bus.rdata, exp);
      end
      rd = bus.rdata;
      last_rd = exp;
      @(posedge clk); #1;
      n_tests++;
      if (bus.ready !== 1'b0 || bus.rdata !== exp || bus.mem_en !== 1'b0) begin
         n_fail++;
         $display("FAIL after_ready addr=%h: ready=%b rdata=%h mem_en=%b, expected 0/%h/0",
                  addr, bus.ready, bus.rdata, bus.mem_en, exp);
      end
      n_tests++;
      if (bus.ddr_vld !== m_vld || bus.ddr_out !== m_ddr ||
          bus.kbd_int !== (INT_EN & m_rdy & m_ie)) begin
         n_fail++;
         $display("FAIL dev_outputs: ddr_vld=%b ddr_out=%h kbd_int=%b, expected %b/%h/%b",
                  bus.ddr_vld, bus.ddr_out, bus.kbd_int, m_vld, m_ddr, INT_EN & m_rdy & m_ie);
      end
   endtask

   task automatic test_reset();
      logic [15:0] rd;
      rst_n = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      n_tests++;
      if (bus.ready !== 1'b0 || bus.rdata !== 16'h0) begin
         n_fail++;
         $display("FAIL reset_ready_rdata: got %b/%h, expected 0/0000", bus.ready, bus.rdata);
      end
      n_tests++;
      if ({bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata} !== 34'h0) begin
         n_fail++;
         $display("FAIL reset_mem_port: en=%b we=%b addr=%h wdata=%h, expected all 0",
                  bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata);
      end
      n_tests++;
      if (bus.ddr_vld !== 1'b0 || bus.ddr_out !== 8'h0 || bus.kbd_int !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_dev: ddr_vld=%b ddr_out=%h kbd_int=%b, expected 0/00/0",
                  bus.ddr_vld, bus.ddr_out, bus.kbd_int);
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
      access(1'b0, A_KBSR, 16'h0, 1'b0, 8'h0, 1'b0, 1'b0, rd);
      n_tests++;
      if (rd !== 16'h0000) begin n_fail++; $display("FAIL reset_kbsr: got %h, expected 0000", rd); end
      access(1'b0, A_KBDR, 16'h0, 1'b0, 8'h0, 1'b0, 1'b0, rd);
      n_tests++;
      if (rd !== 16'h0000) begin n_fail++; $display("FAIL reset_kbdr: got %h, expected 0000", rd); end
      access(1'b0, A_DSR, 16'h0, 1'b0, 8'h0, 1'b0, 1'b0, rd);
      n_tests++;
      if (rd !== 16'h8000) begin n_fail++; $display("FAIL reset_dsr: got %h, expected 8000", rd); end
   endtask

   task automatic test_mem_read();
      logic [15:0] rd;
      access(1'b0, 16'h3000, 16'h0, 1'b0, 8'h0, 1'b0, 1'b0, rd);
      n_tests++;
      if (rd !== 16'h1234) begin n_fail++; $display("FAIL mem_read_3000: got %h, expected 1234", rd); end
      access(1'b1, 16'h3001, 16'hBEEF, 1'b0, 8'h0, 1'b0, 1'b0, rd);
      access(1'b0, 16'h3001, 16'h0, 1'b0, 8'h0, 1'b0, 1'b0, rd);
      n_tests++;
      if (rd !== 16'hBEEF) begin n_fail++; $display("FAIL mem_write_read: got %h, expected beef", rd); end
   endtask

   task automatic test_kbd();
      logic [15:0] rd;
      kbd_strobe(8'h41);
      access(1'b0, A_KBSR, 16'h0, 1'b0, 8'h0, 1'b0, 1'b0, rd);
      n_tests++;
      if (rd !== 16'h8000) begin n_fail++; $display("FAIL kbd_kbsr_set: got %h, expected 8000", rd); end
      access(1'b0, A_KBDR, 16'h0, 1'b0, 8'h0, 1'b0, 1'b0, rd);
      n_tests++;
      if (rd !== 16'h0041) begin n_fail++; $display("FAIL kbd_kbdr: got %h, expected 0041", rd); end
      access(1'b0, A_KBSR, 16'h0, 1'b0, 8'h0, 1'b0, 1'b0, rd);
      n_tests++;
      if (rd !== 16'h0000) begin n_fail++; $display("FAIL kbd_kbsr_clr: got %h, expected 0000", rd); end
      // Overrun, then a strobe landing on a KBDR read
      kbd_strobe(8'h61);
      kbd_strobe(8'h62);
      access(1'b0, A_KBDR, 16'h0, 1'b1, 8'h22, 1'b0, 1'b0, rd);
      n_tests++;
      if (rd !== 16'h0062) begin n_fail++; $display("FAIL kbd_overrun_old: got %h, expected 0062", rd); end
      access(1'b0, A_KBSR, 16'h0, 1'b0, 8'h0, 1'b0, 1'b0, rd);
      n_tests++;
      if (rd !== 16'h8000) begin n_fail++; $display("FAIL kbd_same_cycle_flag: got %h, expected 8000", rd); end
      access(1'b1, A_KBDR, 16'hFFFF, 1'b0, 8'h0, 1'b0, 1'b0, rd);
      access(1'b0, A_KBDR, 16'h0, 1'b0, 8'h0, 1'b0, 1'b0, rd);
      n_tests++;
      if (rd !== 16'h0022) begin n_fail++; $display("FAIL kbd_same_cycle_new: got %h, expected 0022", rd); end
   endtask

   task automatic test_ddr();
      logic [15:0] rd;
      access(1'b1, A_DDR, 16'h0058, 1'b0, 8'h0, 1'b0, 1'b0, rd);
      n_tests++;
      if (bus.ddr_vld !== 1'b1 || bus.ddr_out !== 8'h58) begin
         n_fail++;
         $display("FAIL ddr_write: ddr_vld=%b ddr_out=%h, expected 1/58", bus.ddr_vld, bus.ddr_out);
      end
      access(1'b0, A_DSR, 16'h0, 1'b0, 8'h0, 1'b0, 1'b0, rd);
      n_tests++;
      if (rd !== 16'h0000) begin n_fail++; $display("FAIL dsr_busy: got %h, expected 0000", rd); end
      access(1'b0, A_DDR, 16'h0, 1'b0, 8'h0, 1'b0, 1'b0, rd);
      n_tests++;
      if (rd !== 16'h0000) begin n_fail++; $display("FAIL ddr_read_zero: got %h, expected 0000", rd); end
      disp_ack_strobe();
      access(1'b0, A_DSR, 16'h0, 1'b0, 8'h0, 1'b0, 1'b0, rd);
      n_tests++;
      if (rd !== 16'h8000 || bus.ddr_vld !== 1'b0) begin
         n_fail++;
         $display("FAIL dsr_after_ack: dsr=%h ddr_vld=%b, expected 8000/0", rd, bus.ddr_vld);
      end
      access(1'b1, A_DDR, 16'h0061, 1'b0, 8'h0, 1'b1, 1'b0, rd);
      access(1'b0, A_DSR, 16'h0, 1'b0, 8'h0, 1'b0, 1'b0, rd);
      n_tests++;
      if (rd !== 16'h0000 || bus.ddr_vld !== 1'b1) begin
         n_fail++;
         $display("FAIL ddr_write_vs_ack: dsr=%h ddr_vld=%b, expected 0000/1", rd, bus.ddr_vld);
      end
      access(1'b1, A_DDR, 16'h0062, 1'b0, 8'h0, 1'b0, 1'b0, rd);
      n_tests++;
      if (bus.ddr_out !== 8'h62) begin
         n_fail++;
         $display("FAIL ddr_overwrite: got %h, expected 62", bus.ddr_out);
      end
   endtask

`ifdef MIO_KBD_INT_EN
   task automatic test_kbd_int();
      logic [15:0] rd;
      access(1'b0, A_KBDR, 16'h0, 1'b0, 8'h0, 1'b0, 1'b0, rd);
      access(1'b1, A_KBSR, 16'h4000, 1'b0, 8'h0, 1'b0, 1'b0, rd);
      kbd_strobe(8'h33);
      n_tests++;
      if (bus.kbd_int !== 1'b0) begin n_fail++; $display("FAIL kbd_int_lag: got %b, expected 0", bus.kbd_int); end
      @(posedge clk); #1;
      n_tests++;
      if (bus.kbd_int !== 1'b1) begin n_fail++; $display("FAIL kbd_int_set: got %b, expected 1", bus.kbd_int); end
      access(1'b0, A_KBSR, 16'h0, 1'b0, 8'h0, 1'b0, 1'b0, rd);
      n_tests++;
      if (rd !== 16'hC000) begin n_fail++; $display("FAIL kbd_int_kbsr: got %h, expected c000", rd); end
      access(1'b0, A_KBDR, 16'h0, 1'b0, 8'h0, 1'b0, 1'b0, rd);
      n_tests++;
      if (bus.kbd_int !== 1'b0) begin n_fail++; $display("FAIL kbd_int_clr: got %b, expected 0", bus.kbd_int); end
   endtask
`else
   task automatic test_kbd_int();
      logic [15:0] rd;
      access(1'b1, A_KBSR, 16'hC000, 1'b0, 8'h0, 1'b0, 1'b0, rd);
      kbd_strobe(8'h33);
      @(posedge clk); #1;
      access(1'b0, A_KBSR, 16'h0, 1'b0, 8'h0, 1'b0, 1'b0, rd);
      n_tests++;
      if (rd !== 16'h8000 || bus.kbd_int !== 1'b0) begin
         n_fail++;
         $display("FAIL kbd_int_off: kbsr=%h kbd_int=%b, expected 8000/0", rd, bus.kbd_int);
      end
   endtask
`endif

   task automatic test_reset_mid();
      logic [15:0] rd;
      logic        saw;
      access(1'b1, A_DDR, 16'h0077, 1'b0, 8'h0, 1'b0, 1'b0, rd);
      bus.req = 1'b1; bus.r_w = 1'b0; bus.mar = 16'h1234;
      @(posedge clk); #1;
      bus.req = 1'b0;
      @(posedge clk); #1;
      n_tests++;
      if (bus.mem_en !== 1'b1) begin n_fail++; $display("FAIL mid_mem_en: got %b, expected 1", bus.mem_en); end
      rst_n = 1'b0;
      #1;
      n_tests++;
      if (bus.mem_en !== 1'b0 || bus.ddr_vld !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_async_reset: mem_en=%b ddr_vld=%b, expected 0/0", bus.mem_en, bus.ddr_vld);
      end
      saw = 1'b0;
      repeat (2) begin @(posedge clk); #1; if (bus.ready !== 1'b0) saw = 1'b1; end
      rst_n = 1'b1;
      model_reset();
      repeat (6) begin @(posedge clk); #1; if (bus.ready !== 1'b0) saw = 1'b1; end
      n_tests++;
      if (saw !== 1'b0) begin n_fail++; $display("FAIL mid_no_ready: got ready activity, expected none"); end
      access(1'b0, A_DSR, 16'h0, 1'b0, 8'h0, 1'b0, 1'b0, rd);
      n_tests++;
      if (rd !== 16'h8000) begin n_fail++; $display("FAIL mid_dsr: got %h, expected 8000", rd); end
   endtask

   task automatic test_random();
      logic [15:0] rd, addr;
      logic        kv, ack, hold;
      for (int i = 0; i < 120; i++) begin
         kv   = ($urandom_range(0, 3) == 0);
         ack  = ($urandom_range(0, 3) == 0);
         hold = ($urandom_range(0, 3) == 0);
         case ($urandom_range(0, 3))
            0:       addr = A_KBSR;
            1:       addr = A_KBDR;
            2:       addr = A_DSR;
            default: addr = A_DDR;
         endcase
         case ($urandom_range(0, 5))
            0: access(1'b0, 16'($urandom), 16'h0, kv, 8'($urandom), ack, hold, rd);
            1: access(1'b1, 16'($urandom), 16'($urandom), kv, 8'($urandom), ack, hold, rd);
            2: access(1'b0, addr, 16'h0, kv, 8'($urandom), ack, hold, rd);
            3: access(1'b1, addr, 16'($urandom), kv, 8'($urandom), ack, hold, rd);
            4: kbd_strobe(8'($urandom));
            default: disp_ack_strobe();
         endcase
      end
   endtask

   initial begin
      bus.req = 1'b0; bus.r_w = 1'b0; bus.mar = '0; bus.wdata = '0;
      bus.kbd_vld = 1'b0; bus.kbd_char = '0; bus.disp_ack = 1'b0;
      model_reset();
      pl_en = 1'b1;
      for (int i = 0; i < 256; i++) begin
         pl_idx = 8'(i);
         pl_val = (i == 0) ? 16'h1234 : 16'($urandom);
         m_mem[i] = pl_val;
         @(posedge clk); #1;
      end
      pl_en = 1'b0;
      test_reset();
      test_mem_read();
      test_kbd();
      test_ddr();
      test_kbd_int();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

endmodule
